multi_cycle_ctr: RTL

//  Multi-cycle control unit for the MIPS-like core, replacing the single-cycle decoder.

---
 rtl/ctr_pkg.sv | 75 +++++++
 rtl/ctr_decode.sv | 44 ++++
 rtl/multi_cycle_ctr.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ctr_pkg.sv
// Shared encodings for the multi-cycle control unit: ALU ops, opcode/funct
// values, FSM states, instruction classes and datapath mux selects.
package ctr_pkg;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [1:0] PCSRC_PC4    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] REGDST_RD = 2'd0;
  localparam logic [1:0] REGDST_RT = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_PC4 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_JUMP
  } state_t;

  typedef enum logic [3:0] {
    C_NONE,
    C_RALU,
    C_LW,
    C_SW,
    C_ADDI,
    C_BEQ,
    C_J,
    C_JAL,
    C_JR
  } iclass_t;

  // ALU_NONE doubles as "not an ALU funct" so the decoder can flag it.
  function automatic logic [3:0] funct_alu_op(input logic [5:0] funct);
    case (funct)
      F_ADD:   return ALU_ADD;
      F_SUB:   return ALU_SUB;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_SLT:   return ALU_SLT;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ctr_decode.sv
// Combinational instruction decoder: classifies the IR word, gives the
// R-type ALU op and flags anything outside the supported set.
module ctr_decode
  import ctr_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output iclass_t            iclass,
  output logic [3:0]         r_alu_op,
  output logic               illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_bits;

  assign opcode      = instr[INSTR_W-1 -: 6];
  assign funct       = instr[5:0];
  assign unused_bits = ^instr[INSTR_W-7:6];

  always_comb begin
    iclass   = C_NONE;
    r_alu_op = funct_alu_op(funct);
    case (opcode)
      OP_RTYPE: begin
        if (funct == F_JR) begin
          iclass = C_JR;
        end else if (r_alu_op != ALU_NONE) begin
          iclass = C_RALU;
        end
      end
      OP_LW:   iclass = C_LW;
      OP_SW:   iclass = C_SW;
      OP_ADDI: iclass = C_ADDI;
      OP_BEQ:  iclass = C_BEQ;
      OP_J:    iclass = C_J;
      OP_JAL:  iclass = C_JAL;
      default: iclass = C_NONE;
    endcase
    illegal = (iclass == C_NONE);
  end

endmodule

// File: rtl/multi_cycle_ctr.sv
// Multi-cycle MIPS-like control unit: FSM over fetch/decode/exec/mem/wb and
// branch/jump states, producing per-cycle datapath enables and selects.
module multi_cycle_ctr
  import ctr_pkg::*;
#(
  parameter int INSTR_W       = 32,
  parameter int ALUOP_W       = 4,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  input  logic               stall,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_sel,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               instr_done,
  output logic               illegal
);

  state_t     state_q;
  state_t     state_d;
  iclass_t    cls_q;
  iclass_t    dec_cls;
  logic [3:0] alu_q;
  logic [3:0] dec_alu;
  logic       dec_illegal;
  logic       mem_rdy;
  logic       go;

  ctr_decode #(
    .INSTR_W(INSTR_W)
  ) u_decode (
    .instr   (instr),
    .iclass  (dec_cls),
    .r_alu_op(dec_alu),
    .illegal (dec_illegal)
  );

  assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign go      = !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_NONE;
      alu_q   <= ALU_NONE;
    end else begin
      state_q <= state_d;
      if (go && state_q == S_DECODE) begin
        cls_q <= dec_cls;
        alu_q <= dec_alu;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (go) begin
      case (state_q)
        S_IDLE:   state_d = S_FETCH;
        S_FETCH:  if (mem_rdy) state_d = S_DECODE;
        S_DECODE: begin
          case (dec_cls)
            C_RALU, C_LW, C_SW, C_ADDI: state_d = S_EXEC;
            C_BEQ:                      state_d = S_BRANCH;
            C_J, C_JAL, C_JR:           state_d = S_JUMP;
            default:                    state_d = S_FETCH;
          endcase
        end
        S_EXEC:   state_d = (cls_q == C_LW || cls_q == C_SW) ? S_MEM : S_WB;
        S_MEM:    if (mem_rdy) state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  // Every write/request term is qualified by go, so a stalled cycle is inert.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PCSRC_PC4;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = REGDST_RD;
    wb_sel        = WBSEL_ALU;
    alu_src       = 1'b0;
    alu_op        = ALUOP_W'(ALU_NONE);
    instr_done    = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = go;
        if (mem_rdy) begin
          ir_write = go;
          pc_write = go;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          illegal    = go;
          instr_done = go;
        end
      end
      S_EXEC: begin
        alu_src = (cls_q == C_RALU);
        alu_op  = (cls_q == C_RALU) ? ALUOP_W'(alu_q) : ALUOP_W'(ALU_ADD);
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = go && (cls_q == C_LW);
        mem_write = go && (cls_q == C_SW);
        if (mem_rdy && cls_q == C_SW) begin
          instr_done = go;
        end
      end
      S_WB: begin
        reg_write  = go;
        instr_done = go;
        reg_dst    = (cls_q == C_RALU) ? REGDST_RD : REGDST_RT;
        wb_sel     = (cls_q == C_LW) ? WBSEL_MEM : WBSEL_ALU;
      end
      S_BRANCH: begin
        alu_op        = ALUOP_W'(ALU_SUB);
        alu_src       = 1'b1;
        pc_write_cond = go;
        pc_src        = PCSRC_BRANCH;
        instr_done    = go;
      end
      S_JUMP: begin
        pc_write   = go;
        instr_done = go;
        pc_src     = (cls_q == C_JR) ? PCSRC_RS : PCSRC_JUMP;
        if (cls_q == C_JAL) begin
          reg_write = go;
          reg_dst   = REGDST_RA;
          wb_sel    = WBSEL_PC4;
        end
      end
      default: begin
        pc_src = PCSRC_PC4;
      end
    endcase
  end

endmodule
